// File: rtl/if_id_register.sv
// IF/ID pipeline register: aligns PC+1 with synchronous-ROM data and squashes wrong-path fetches.
// Optional IFID_PERF_COUNTERS_EN adds saturating stall_count / flush_count outputs.
module if_id_register #(
    parameter int width_B = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [width_B-1:0] PC_sumado_in,
    input  logic [width_B-1:0] Instruction_in,
    input  logic               IFID_write,
    input  logic               flush,
    output logic [width_B-1:0] PC_sumado_out,
    output logic [width_B-1:0] Instruction_out,
    output logic               valid_out
`ifdef IFID_PERF_COUNTERS_EN
    ,
    output logic [15:0]        stall_count,
    output logic [15:0]        flush_count
`endif
);

    localparam logic [1:0] FILL   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] SQUASH = 2'd2;

    logic [1:0]         state;
    logic [width_B-1:0] pc_pipe;

    // ROM data arriving now belongs to the PC+1 captured on the previous edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= FILL;
            pc_pipe         <= '0;
            PC_sumado_out   <= '0;
            Instruction_out <= '0;
            valid_out       <= 1'b0;
        end else if (flush) begin
            state           <= SQUASH;
            pc_pipe         <= PC_sumado_in;
            PC_sumado_out   <= '0;
            Instruction_out <= '0;
            valid_out       <= 1'b0;
        end else if (IFID_write) begin
            pc_pipe <= PC_sumado_in;
            state   <= RUN;
            case (state)
                RUN: begin
                    PC_sumado_out   <= pc_pipe;
                    Instruction_out <= Instruction_in;
                    valid_out       <= 1'b1;
                end
                default: begin
                    PC_sumado_out   <= '0;
                    Instruction_out <= '0;
                    valid_out       <= 1'b0;
                end
            endcase
        end
    end

`ifdef IFID_PERF_COUNTERS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (flush && flush_count != 16'hFFFF)
                flush_count <= flush_count + 16'd1;
            if (!flush && !IFID_write && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_register.sv
// Bench for if_id_register: fetch/ROM model plus transaction-level
// expectation of what decode should see after each edge.
module tb_if_id_register;

    logic        clk;
    logic        rst_n;
    logic [31:0] PC_sumado_in;
    logic [31:0] Instruction_in;
    logic        IFID_write;
    logic        flush;
    logic [31:0] PC_sumado_out;
    logic [31:0] Instruction_out;
    logic        valid_out;
`ifdef IFID_PERF_COUNTERS_EN
    logic [15:0] stall_count;
    logic [15:0] flush_count;
`endif

    if_id_register #(.width_B(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .PC_sumado_in(PC_sumado_in),
        .Instruction_in(Instruction_in),
        .IFID_write(IFID_write),
        .flush(flush),
        .PC_sumado_out(PC_sumado_out),
        .Instruction_out(Instruction_out),
        .valid_out(valid_out)
`ifdef IFID_PERF_COUNTERS_EN
        ,
        .stall_count(stall_count),
        .flush_count(flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fetch stage and synchronous ROM
    logic [31:0] rom [64];
    logic [31:0] pc;
    logic [31:0] rom_q;
    assign PC_sumado_in   = pc + 32'd1;
    assign Instruction_in = rom_q;

    // Reference: the one fetch in flight, and what decode holds
    bit          pend_v;
    bit          pend_k;
    logic [31:0] pend_pc;
    logic [31:0] exp_pc;
    logic [31:0] exp_ins;
    logic        exp_v;
    int          exp_stall;
    int          exp_flush;

    int checks;
    int failures;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_model();
        chk("model_pc", PC_sumado_out, exp_pc);
        chk("model_ins", Instruction_out, exp_ins);
        chk("model_valid", {31'd0, valid_out}, {31'd0, exp_v});
`ifdef IFID_PERF_COUNTERS_EN
        chk("model_stalls", {16'd0, stall_count}, exp_stall);
        chk("model_flushes", {16'd0, flush_count}, exp_flush);
`endif
    endtask

    task automatic chk_out(input string tag, input logic [31:0] p,
                           input logic [31:0] ins, input logic v);
        chk({tag, "_pc"}, PC_sumado_out, p);
        chk({tag, "_ins"}, Instruction_out, ins);
        chk({tag, "_valid"}, {31'd0, valid_out}, {31'd0, v});
    endtask

    task automatic model_reset();
        pc = 0;
        rom_q = 0;
        pend_v = 0;
        pend_k = 0;
        pend_pc = 0;
        exp_pc = 0;
        exp_ins = 0;
        exp_v = 0;
        exp_stall = 0;
        exp_flush = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        IFID_write = 1'b0;
        flush = 1'b0;
        #2;
        model_reset();
        chk_out("reset", 32'd0, 32'd0, 1'b0);
        chk_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input bit w, input bit f, input logic [31:0] tgt);
        logic [31:0] a;
        IFID_write = w;
        flush = f;
        @(posedge clk);
        #1;
        if (f) begin
            exp_pc = 0;
            exp_ins = 0;
            exp_v = 0;
            pend_v = 1;
            pend_k = 1;
            pend_pc = pc + 32'd1;
            if (exp_flush < 65535) exp_flush++;
        end else if (w) begin
            if (pend_v && !pend_k) begin
                a = pend_pc - 32'd1;
                exp_pc = pend_pc;
                exp_ins = rom[a[5:0]];
                exp_v = 1;
            end else begin
                exp_pc = 0;
                exp_ins = 0;
                exp_v = 0;
            end
            pend_v = 1;
            pend_k = 0;
            pend_pc = pc + 32'd1;
        end else begin
            if (exp_stall < 65535) exp_stall++;
        end
        if (f || w) rom_q = rom[pc[5:0]];
        if (f) pc = tgt;
        else if (w) pc = pc + 32'd1;
        chk_model();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 64; i++) rom[i] = $urandom;
        rom[0] = 32'h11;
        rom[1] = 32'h22;
        rom[2] = 32'h33;
        rom[3] = 32'h44;
        rom[8] = 32'h88;
        rst_n = 1'b0;
        IFID_write = 1'b0;
        flush = 1'b0;
        model_reset();
        #12;
        do_reset();

        // Free run then flush to address 8
        step(1, 0, 0);
        chk_out("fill1", 32'd0, 32'd0, 1'b0);
        step(1, 0, 0);
        chk_out("first", 32'd1, 32'h11, 1'b1);
        step(1, 0, 0);
        chk_out("second", 32'd2, 32'h22, 1'b1);
        step(1, 1, 32'd8);
        chk_out("flush_n", 32'd0, 32'd0, 1'b0);
        step(1, 0, 0);
        chk_out("flush_n1", 32'd0, 32'd0, 1'b0);
        step(1, 0, 0);
        chk_out("target", 32'd9, 32'h88, 1'b1);

        // Stall while (2,0x22) is in decode
        do_reset();
        repeat (3) step(1, 0, 0);
        chk_out("pre_stall", 32'd2, 32'h22, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0);
            chk_out("stall_hold", 32'd2, 32'h22, 1'b1);
        end
        step(1, 0, 0);
        chk_out("post_stall", 32'd3, 32'h33, 1'b1);

        // Flush coinciding with stall
        step(0, 1, 32'd20);
        chk_out("flush_stall", 32'd0, 32'd0, 1'b0);
        step(1, 0, 0);
        chk_out("flush_stall_sq", 32'd0, 32'd0, 1'b0);
        step(1, 0, 0);
        chk_out("flush_stall_tgt", 32'd21, rom[20], 1'b1);

        // Back-to-back flushes
        step(1, 1, 32'd30);
        step(1, 1, 32'd40);
        chk_out("b2b_0", 32'd0, 32'd0, 1'b0);
        step(1, 0, 0);
        chk_out("b2b_1", 32'd0, 32'd0, 1'b0);
        step(1, 0, 0);
        chk_out("b2b_tgt", 32'd41, rom[40], 1'b1);

        // Reset in the middle of a squash
        step(1, 1, 32'd12);
        @(negedge clk);
        do_reset();
        step(1, 0, 0);
        chk_out("rst_fill", 32'd0, 32'd0, 1'b0);
        step(1, 0, 0);
        chk_out("rst_first", 32'd1, 32'h11, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                 32'($urandom_range(0, 63)));
            if (i == 200) begin
                @(negedge clk);
                do_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_register.md
# if_id_register

Pipeline register between instruction fetch and decode. It takes the fetch stage's PC+1 value and the synchronous-ROM instruction, and re-aligns them for the ROM's one-cycle read latency. It presents an aligned {PC+1, instruction, valid} triple to decode. Stall comes from the hazard detection unit and flush from branch resolution; the block squashes the wrong-path fetch that the synchronous ROM is still producing.

## Interface
- width_B, 32, data width of PC and instruction
- clk  input  1  rising-edge clock shared with fetch stage
- rst_n  input  1  asynchronous, active-low reset
- PC_sumado_in  input  width_B  PC+1 of the address currently driven to the ROM (combinational from fetch)
- Instruction_in  input  width_B  ROM data output; belongs to the address presented one cycle earlier
- IFID_write  input  1  1 = advance, 0 = stall (hold all state); driven together with fetch PC_write
- flush  input  1  branch taken: discard the current and the in-flight instruction
- PC_sumado_out  output  width_B  PC+1 of the instruction in decode
- Instruction_out  output  width_B  instruction in decode; 0 (NOP) when invalid
- valid_out  output  1  Instruction_out / PC_sumado_out are a real instruction

## Operation
- Internal align register pc_pipe: loads PC_sumado_in on every edge with IFID_write=1. Pairs PC+1 with the ROM data arriving next cycle.
- Output register loads {pc_pipe, Instruction_in} on each advancing edge unless squashed.
- State machine, 2-bit:
  - FILL (reset state): ROM output not yet valid. Next advancing edge -> RUN, output register loads NOP, valid_out=0.
  - RUN: advancing edge loads {pc_pipe, Instruction_in}, valid_out=1. flush=1 -> SQUASH.
  - SQUASH: one wrong-path ROM word still in flight. Advancing edge loads NOP/PC 0, valid_out=0, -> RUN. flush=1 again -> stays SQUASH.
- flush on an edge: output register loads NOP, PC_sumado_out=0, valid_out=0, regardless of state or IFID_write. flush wins over stall; pc_pipe still loads PC_sumado_in (the branch target's fetch begins).
- Stall (IFID_write=0, flush=0): state, pc_pipe and outputs hold. The ROM address is held by fetch, so Instruction_in is stable on release.
- Squashed words never reach decode; a NOP is an all-zero word.

## Timing
- Reset (async assert, sync-safe release): PC_sumado_out=0, Instruction_out=0, valid_out=0, pc_pipe=0, state=FILL.
- Latency: PC value to decode output = 2 edges (ROM + this register); Instruction_in to output = 1 edge.
- After reset release, first valid_out=1 appears on the 2nd advancing edge, carrying instruction @0 with PC_sumado_out=1.
- Flush at edge N: valid_out=0 after N and N+1 (N+1 counted in advancing edges). The branch-target instruction is valid after N+2.
- Reset asserted mid-stall or mid-SQUASH: immediate return to reset values; the pending squash is discarded.
- No arithmetic; all widths width_B, passthrough only.

## Configuration
- IFID_PERF_COUNTERS_EN defined: adds outputs stall_count[15:0] and flush_count[15:0].
  - Each increments on an edge with IFID_write=0 and flush=0, or on an edge with flush=1, respectively.
  - Each saturates at 16'hFFFF and is cleared by rst_n.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset then free-run, ROM[0..3]=0x11,0x22,0x33,0x44 -> valid_out 0,0,1,1,… with (PC_sumado_out, Instruction_out) = (1,0x11),(2,0x22),(3,0x33).
- Stall 3 cycles while (2,0x22) is in decode -> outputs hold (2,0x22,valid=1) for 3 cycles, then (3,0x33) on the first advancing edge.
- Flush while (2,0x22) is in decode, target address 8 (ROM[8]=0x88) -> two cycles of (0,0,valid=0), then (9,0x88,valid=1).
- flush=1 and IFID_write=0 on the same edge -> flush wins: NOP, valid 0; the following squash still happens.
- Back-to-back flush on consecutive edges -> valid_out stays 0 until 2 advancing edges after the last flush.
- rst_n pulsed low mid-SQUASH -> all outputs 0 asynchronously. Sequence restarts at instruction @0. With IFID_PERF_COUNTERS_EN defined, counters read 0, then count 3 stalls / 1 flush in the scenarios above.
